// File: rtl/beeb_sched_pkg.sv
// Shared constants for the Beeb external bus scheduler: owner codes, FSM
// state encodings, the idle-slot address and the default page geometry.
package beeb_sched_pkg;

  localparam int ADDR_BITS_DEF = 15;
  localparam int PAGE_BITS_DEF = 8;
  localparam int NPAGES        = 1 << (ADDR_BITS_DEF - PAGE_BITS_DEF);

  localparam logic [1:0] OWN_IDLE  = 2'd0;
  localparam logic [1:0] OWN_CPU   = 2'd1;
  localparam logic [1:0] OWN_SCRUB = 2'd2;

  localparam logic [0:0] SEEK   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  localparam logic [15:0] IDLE_ADDR = 16'h0000;

endpackage

// File: rtl/beeb_bus_scheduler_dirty_page_map.sv
// One dirty bit per scrubbable page. A set and a clear of the same page in
// the same cycle leaves the page dirty, so no fast write is ever lost.
module dirty_page_map
  import beeb_sched_pkg::*;
#(
  parameter int IDX_BITS = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [IDX_BITS-1:0] set_idx,
  input  logic                clr_en,
  input  logic [IDX_BITS-1:0] clr_idx,
  input  logic [IDX_BITS-1:0] test_idx,
  output logic                test_bit,
  output logic                dirty_any
);

  localparam int NBITS = 1 << IDX_BITS;

  logic [NBITS-1:0] map_q;
  logic [NBITS-1:0] map_next;

  // NOTE: map_next takes the current map first so every path assigns it and no latch is inferred.
  always_comb begin
    map_next = map_q;
    if (clr_en) map_next[clr_idx] = 1'b0;
    if (set_en) map_next[set_idx] = 1'b1;
  end

  assign test_bit = map_q[test_idx];

  // NOTE: the map is plain flops, not a RAM, so it can and must be cleared by reset.
  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      map_q     <= '0;
      dirty_any <= 1'b0;
    end else begin
      map_q     <= map_next;
      dirty_any <= |map_next;
    end
  end

endmodule

// File: rtl/beeb_bus_scheduler.sv
// Arbitrates each slow Beeb bus slot between CPU, dirty-page scrub and idle.
// Optional slot statistics are built when BUS_SCHED_STATS_EN is defined.
module beeb_bus_scheduler
  import beeb_sched_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEF,
  parameter int PAGE_BITS = PAGE_BITS_DEF
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_reset,
  input  logic                 slot,
  input  logic                 cpu_req,
  input  logic [15:0]          cpu_addr,
  input  logic                 cpu_we,
  input  logic [7:0]           cpu_do,
  output logic                 cpu_done,
  input  logic                 mark_we,
  input  logic [ADDR_BITS-1:0] mark_addr,
  input  logic                 scrub_en,
  output logic [ADDR_BITS-1:0] scrub_A,
  input  logic [7:0]           scrub_D,
  output logic [15:0]          bus_addr,
  output logic                 bus_we,
  output logic [7:0]           bus_do,
  output logic [1:0]           bus_owner,
`ifdef BUS_SCHED_STATS_EN
  input  logic                 stat_clr,
  output logic [15:0]          stat_cpu,
  output logic [15:0]          stat_scrub,
  output logic [15:0]          stat_idle,
`endif
  output logic                 dirty_any
);

  localparam int IDX_BITS = ADDR_BITS - PAGE_BITS;

  logic [0:0]           state;
  logic [IDX_BITS-1:0]  ptr;
  logic [IDX_BITS-1:0]  page;
  logic [PAGE_BITS-1:0] offset;
  logic                 remark;
  logic                 fresh;

  logic                 test_bit;
  logic                 grant_cpu;
  logic                 grant_scrub;
  logic                 last_byte;
  logic                 active_mark;
  logic                 map_clr;
  logic [IDX_BITS-1:0]  mark_idx;
  logic                 unused_mark_offset;

  assign mark_idx           = mark_addr[ADDR_BITS-1:PAGE_BITS];
  assign unused_mark_offset = ^mark_addr[PAGE_BITS-1:0];
  assign scrub_A            = {page, offset};

  // fresh blocks a scrub grant until scrub_D has caught up with a new scrub_A.
  assign grant_cpu   = slot & cpu_req;
  assign grant_scrub = slot & ~cpu_req & (state == ACTIVE) & scrub_en & ~fresh;
  assign last_byte   = grant_scrub & (offset == '1);
  assign active_mark = mark_we & (state == ACTIVE) & (mark_idx == page);
  assign map_clr     = last_byte & ~remark;

  dirty_page_map #(
    .IDX_BITS (IDX_BITS)
  ) u_map (
    .clk       (cpu_clk),
    .reset     (cpu_reset),
    .set_en    (mark_we),
    .set_idx   (mark_idx),
    .clr_en    (map_clr),
    .clr_idx   (page),
    .test_idx  (ptr),
    .test_bit  (test_bit),
    .dirty_any (dirty_any)
  );

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      bus_owner <= OWN_IDLE;
      bus_addr  <= IDLE_ADDR;
      bus_we    <= 1'b0;
      bus_do    <= 8'h00;
      cpu_done  <= 1'b0;
    end else if (slot) begin
      cpu_done <= (bus_owner == OWN_CPU);
      if (grant_cpu) begin
        bus_owner <= OWN_CPU;
        bus_addr  <= cpu_addr;
        bus_we    <= cpu_we;
        bus_do    <= cpu_do;
      end else if (grant_scrub) begin
        bus_owner <= OWN_SCRUB;
        bus_addr  <= {{(16-ADDR_BITS){1'b0}}, scrub_A};
        bus_we    <= 1'b1;
        bus_do    <= scrub_D;
      end else begin
        bus_owner <= OWN_IDLE;
        bus_addr  <= IDLE_ADDR;
        bus_we    <= 1'b0;
        bus_do    <= 8'h00;
      end
    end else begin
      cpu_done <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_reset) begin
      state  <= SEEK;
      ptr    <= '0;
      page   <= '0;
      offset <= '0;
      remark <= 1'b0;
      fresh  <= 1'b0;
    end else begin
      fresh <= 1'b0;
      case (state)
        SEEK: begin
          ptr <= ptr + IDX_BITS'(1);
          if (test_bit) begin
            state  <= ACTIVE;
            page   <= ptr;
            offset <= '0;
            remark <= 1'b0;
            fresh  <= 1'b1;
          end
        end
        ACTIVE: begin
          if (active_mark) remark <= 1'b1;
          if (grant_scrub) begin
            if (offset == '1) begin
              state <= SEEK;
              ptr   <= page + IDX_BITS'(1);
            end else begin
              offset <= offset + PAGE_BITS'(1);
              fresh  <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef BUS_SCHED_STATS_EN
  always_ff @(posedge cpu_clk) begin
    if (cpu_reset || stat_clr) begin
      stat_cpu   <= 16'h0000;
      stat_scrub <= 16'h0000;
      stat_idle  <= 16'h0000;
    end else if (slot) begin
      if (grant_cpu) begin
        if (stat_cpu != 16'hFFFF) stat_cpu <= stat_cpu + 16'd1;
      end else if (grant_scrub) begin
        if (stat_scrub != 16'hFFFF) stat_scrub <= stat_scrub + 16'd1;
      end else begin
        if (stat_idle != 16'hFFFF) stat_idle <= stat_idle + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_beeb_bus_scheduler.sv
// Scoreboard bench for beeb_bus_scheduler: expected scrub writes are queued
// when pages are marked and popped as scrub slots appear on the bus.
module tb_beeb_bus_scheduler;

  localparam logic [1:0] O_IDLE  = 2'd0;
  localparam logic [1:0] O_CPU   = 2'd1;
  localparam logic [1:0] O_SCRUB = 2'd2;

  logic        cpu_clk = 1'b0;
  logic        cpu_reset, slot, cpu_req, cpu_we, mark_we, scrub_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_do;
  logic [14:0] mark_addr;
  logic        cpu_done, bus_we, dirty_any;
  logic [14:0] scrub_A;
  logic [7:0]  scrub_D, bus_do;
  logic [15:0] bus_addr;
  logic [1:0]  bus_owner;
`ifdef BUS_SCHED_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_cpu, stat_scrub, stat_idle;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  ram [0:32767];

  always #5 cpu_clk = ~cpu_clk;

  always @(posedge cpu_clk) scrub_D <= ram[scrub_A];

  beeb_bus_scheduler dut (
    .cpu_clk   (cpu_clk),
    .cpu_reset (cpu_reset),
    .slot      (slot),
    .cpu_req   (cpu_req),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_do    (cpu_do),
    .cpu_done  (cpu_done),
    .mark_we   (mark_we),
    .mark_addr (mark_addr),
    .scrub_en  (scrub_en),
    .scrub_A   (scrub_A),
    .scrub_D   (scrub_D),
    .bus_addr  (bus_addr),
    .bus_we    (bus_we),
    .bus_do    (bus_do),
    .bus_owner (bus_owner),
`ifdef BUS_SCHED_STATS_EN
    .stat_clr  (stat_clr),
    .stat_cpu  (stat_cpu),
    .stat_scrub(stat_scrub),
    .stat_idle (stat_idle),
`endif
    .dirty_any (dirty_any)
  );

  // Called at a negedge; pulses slot for one cycle and samples the new bus
  // state at the following negedge, then idles so slots are 3 cycles apart.
  task automatic do_slot(output logic [1:0] o, output logic [15:0] a, output logic w,
                         output logic [7:0] d, output logic dn);
    slot = 1'b1;
    @(negedge cpu_clk);
    slot = 1'b0;
    o = bus_owner; a = bus_addr; w = bus_we; d = bus_do; dn = cpu_done;
    @(negedge cpu_clk);
    @(negedge cpu_clk);
  endtask

  task automatic mark(input logic [14:0] addr, input logic [7:0] val);
    ram[addr] = val;
    mark_we   = 1'b1;
    mark_addr = addr;
    @(negedge cpu_clk);
    mark_we   = 1'b0;
  endtask

  task automatic push_page(input logic [6:0] pg);
    for (int i = 0; i < 256; i++) exp_q.push_back({1'b0, pg, i[7:0]});
  endtask

  task automatic test_reset();
    logic [1:0] o; logic [15:0] a; logic w, dn; logic [7:0] d;
    cpu_reset = 1'b1;
    repeat (3) @(negedge cpu_clk);
    n_checks++;
    if (bus_owner !== O_IDLE || bus_addr !== 16'h0000 || bus_we !== 1'b0 || bus_do !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_bus: owner=%0d addr=%h we=%b do=%h, want 0/0000/0/00", bus_owner, bus_addr, bus_we, bus_do);
    end
    n_checks++;
    if (cpu_done !== 1'b0 || scrub_A !== 15'h0000 || dirty_any !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misc: done=%b scrub_A=%h dirty_any=%b, want 0/0000/0", cpu_done, scrub_A, dirty_any);
    end
    cpu_reset = 1'b0;
    @(negedge cpu_clk);
    for (int s = 0; s < 10; s++) begin
      do_slot(o, a, w, d, dn);
      n_checks++;
      if (o !== O_IDLE || a !== 16'h0000 || w !== 1'b0 || dirty_any !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_after_reset: owner=%0d addr=%h we=%b dirty=%b, want 0/0000/0/0", o, a, w, dirty_any);
      end
    end
  endtask

  task automatic test_scrub_page();
    logic [1:0] o; logic [15:0] a, ea; logic w, dn; logic [7:0] d;
    mark(15'h3456, 8'hC3);
    push_page(7'h34);
    for (int s = 0; s < 400 && exp_q.size() > 0; s++) begin
      do_slot(o, a, w, d, dn);
      n_checks++;
      if (o === O_SCRUB) begin
        ea = exp_q.pop_front();
        if (a !== ea || w !== 1'b1 || d !== ram[ea[14:0]]) begin
          n_fail++;
          $display("FAIL scrub_write: addr=%h we=%b do=%h, want %h/1/%h", a, w, d, ea, ram[ea[14:0]]);
        end
      end else if (o !== O_IDLE || a !== 16'h0000 || w !== 1'b0) begin
        n_fail++;
        $display("FAIL scrub_idle: owner=%0d addr=%h we=%b, want 0/0000/0", o, a, w);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || dirty_any !== 1'b0) begin
      n_fail++;
      $display("FAIL scrub_done: left=%0d dirty_any=%b, want 0/0", exp_q.size(), dirty_any);
    end
    exp_q.delete();
  endtask

  task automatic test_cpu_preempt();
    logic [1:0] o; logic [15:0] a, ea; logic w, dn; logic [7:0] d;
    int seen = 0;
    bit injected = 0;
    bit resume_chk = 0;
    mark(15'h2000, 8'hA5);
    push_page(7'h20);
    for (int s = 0; s < 400 && exp_q.size() > 0; s++) begin
      if (seen == 16 && !injected) begin
        injected = 1;
        cpu_req = 1'b1; cpu_addr = 16'hFE40; cpu_we = 1'b1; cpu_do = 8'h0F;
        do_slot(o, a, w, d, dn);
        cpu_req = 1'b0; cpu_we = 1'b0;
        n_checks++;
        if (o !== O_CPU || a !== 16'hFE40 || w !== 1'b1 || d !== 8'h0F || dn !== 1'b0) begin
          n_fail++;
          $display("FAIL cpu_slot: owner=%0d addr=%h we=%b do=%h done=%b, want 1/FE40/1/0F/0", o, a, w, d, dn);
        end
        resume_chk = 1;
      end
      do_slot(o, a, w, d, dn);
      if (resume_chk) begin
        resume_chk = 0;
        n_checks++;
        if (dn !== 1'b1 || o !== O_SCRUB || a !== 16'h2010) begin
          n_fail++;
          $display("FAIL cpu_done_resume: done=%b owner=%0d addr=%h, want 1/2/2010", dn, o, a);
        end
      end
      n_checks++;
      if (o === O_SCRUB) begin
        ea = exp_q.pop_front();
        seen++;
        if (a !== ea || w !== 1'b1 || d !== ram[ea[14:0]]) begin
          n_fail++;
          $display("FAIL cpu_scrub_write: addr=%h we=%b do=%h, want %h/1/%h", a, w, d, ea, ram[ea[14:0]]);
        end
      end else if (o !== O_IDLE || a !== 16'h0000 || w !== 1'b0) begin
        n_fail++;
        $display("FAIL cpu_idle: owner=%0d addr=%h we=%b, want 0/0000/0", o, a, w);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || !injected || dirty_any !== 1'b0) begin
      n_fail++;
      $display("FAIL cpu_page_done: left=%0d injected=%0d dirty_any=%b, want 0/1/0", exp_q.size(), injected, dirty_any);
    end
    exp_q.delete();
  endtask

  task automatic test_remark();
    logic [1:0] o; logic [15:0] a, ea; logic w, dn; logic [7:0] d;
    int seen = 0;
    bit remarked = 0;
    mark(15'h3400, 8'h11);
    push_page(7'h34);
    for (int s = 0; s < 900 && exp_q.size() > 0; s++) begin
      if (seen == 8'h80 && !remarked) begin
        remarked = 1;
        mark(15'h3410, 8'h5A);
        push_page(7'h34);
      end
      do_slot(o, a, w, d, dn);
      n_checks++;
      if (o === O_SCRUB) begin
        ea = exp_q.pop_front();
        seen++;
        if (a !== ea || w !== 1'b1 || d !== ram[ea[14:0]]) begin
          n_fail++;
          $display("FAIL remark_write: addr=%h we=%b do=%h, want %h/1/%h", a, w, d, ea, ram[ea[14:0]]);
        end
        if (seen == 256) begin
          n_checks++;
          if (dirty_any !== 1'b1) begin
            n_fail++;
            $display("FAIL remark_stays_dirty: dirty_any=%b, want 1", dirty_any);
          end
        end
      end else if (o !== O_IDLE || a !== 16'h0000 || w !== 1'b0) begin
        n_fail++;
        $display("FAIL remark_idle: owner=%0d addr=%h we=%b, want 0/0000/0", o, a, w);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || dirty_any !== 1'b0) begin
      n_fail++;
      $display("FAIL remark_done: left=%0d dirty_any=%b, want 0/0", exp_q.size(), dirty_any);
    end
    exp_q.delete();
  endtask

  task automatic test_wrap();
    logic [1:0] o; logic [15:0] a, ea; logic w, dn; logic [7:0] d;
    int seen = 0;
    bit marked = 0;
    mark(15'h7E00, 8'h3C);
    push_page(7'h7E);
    for (int s = 0; s < 1300 && exp_q.size() > 0; s++) begin
      if (seen == 10 && !marked) begin
        marked = 1;
        mark(15'h7F00, 8'h77);
        mark(15'h0000, 8'h99);
        push_page(7'h7F);
        push_page(7'h00);
      end
      do_slot(o, a, w, d, dn);
      n_checks++;
      if (o === O_SCRUB) begin
        ea = exp_q.pop_front();
        seen++;
        if (a !== ea || w !== 1'b1 || d !== ram[ea[14:0]]) begin
          n_fail++;
          $display("FAIL wrap_write: addr=%h we=%b do=%h, want %h/1/%h", a, w, d, ea, ram[ea[14:0]]);
        end
      end else if (o !== O_IDLE || a !== 16'h0000 || w !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_idle: owner=%0d addr=%h we=%b, want 0/0000/0", o, a, w);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || dirty_any !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_done: left=%0d dirty_any=%b, want 0/0", exp_q.size(), dirty_any);
    end
    exp_q.delete();
  endtask

  task automatic test_scrub_en();
    logic [1:0] o; logic [15:0] a, ea; logic w, dn; logic [7:0] d;
    scrub_en = 1'b0;
    mark(15'h1000, 8'hE1);
    for (int s = 0; s < 50; s++) begin
      do_slot(o, a, w, d, dn);
      n_checks++;
      if (o !== O_IDLE || a !== 16'h0000 || w !== 1'b0) begin
        n_fail++;
        $display("FAIL scrub_disabled: owner=%0d addr=%h we=%b, want 0/0000/0", o, a, w);
      end
    end
    n_checks++;
    if (dirty_any !== 1'b1 || scrub_A !== 15'h1000) begin
      n_fail++;
      $display("FAIL scrub_held: dirty_any=%b scrub_A=%h, want 1/1000", dirty_any, scrub_A);
    end
    scrub_en = 1'b1;
    push_page(7'h10);
    for (int s = 0; s < 400 && exp_q.size() > 0; s++) begin
      do_slot(o, a, w, d, dn);
      n_checks++;
      if (o === O_SCRUB) begin
        ea = exp_q.pop_front();
        if (a !== ea || w !== 1'b1 || d !== ram[ea[14:0]]) begin
          n_fail++;
          $display("FAIL enable_write: addr=%h we=%b do=%h, want %h/1/%h", a, w, d, ea, ram[ea[14:0]]);
        end
      end else if (o !== O_IDLE || a !== 16'h0000 || w !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_idle: owner=%0d addr=%h we=%b, want 0/0000/0", o, a, w);
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || dirty_any !== 1'b0) begin
      n_fail++;
      $display("FAIL enable_done: left=%0d dirty_any=%b, want 0/0", exp_q.size(), dirty_any);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_scrub();
    logic [1:0] o; logic [15:0] a; logic w, dn; logic [7:0] d;
    bit got = 0;
    mark(15'h5000, 8'h42);
    for (int s = 0; s < 100 && !got; s++) begin
      do_slot(o, a, w, d, dn);
      if (o === O_SCRUB) got = 1;
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL midreset_start: no scrub slot seen, want one within 100 slots");
    end
    cpu_reset = 1'b1;
    @(negedge cpu_clk);
    cpu_reset = 1'b0;
    n_checks++;
    if (dirty_any !== 1'b0 || bus_owner !== O_IDLE || scrub_A !== 15'h0000) begin
      n_fail++;
      $display("FAIL midreset_state: dirty=%b owner=%0d scrub_A=%h, want 0/0/0000", dirty_any, bus_owner, scrub_A);
    end
    for (int s = 0; s < 50; s++) begin
      do_slot(o, a, w, d, dn);
      n_checks++;
      if (o !== O_IDLE || a !== 16'h0000 || w !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset_idle: owner=%0d addr=%h we=%b, want 0/0000/0", o, a, w);
      end
    end
  endtask

`ifdef BUS_SCHED_STATS_EN
  task automatic test_stats();
    logic [1:0] o; logic [15:0] a; logic w, dn; logic [7:0] d;
    stat_clr = 1'b1;
    @(negedge cpu_clk);
    stat_clr = 1'b0;
    n_checks++;
    if (stat_cpu !== 16'd0 || stat_scrub !== 16'd0 || stat_idle !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clear: cpu=%0d scrub=%0d idle=%0d, want 0/0/0", stat_cpu, stat_scrub, stat_idle);
    end
    repeat (3) do_slot(o, a, w, d, dn);
    cpu_req = 1'b1; cpu_addr = 16'hFE00; cpu_we = 1'b0;
    do_slot(o, a, w, d, dn);
    do_slot(o, a, w, d, dn);
    cpu_req = 1'b0;
    repeat (2) do_slot(o, a, w, d, dn);
    n_checks++;
    if (stat_cpu !== 16'd2 || stat_scrub !== 16'd0 || stat_idle !== 16'd5) begin
      n_fail++;
      $display("FAIL stats_count: cpu=%0d scrub=%0d idle=%0d, want 2/0/5", stat_cpu, stat_scrub, stat_idle);
    end
    slot = 1'b1; stat_clr = 1'b1;
    @(negedge cpu_clk);
    slot = 1'b0; stat_clr = 1'b0;
    n_checks++;
    if (stat_cpu !== 16'd0 || stat_scrub !== 16'd0 || stat_idle !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_clr_priority: cpu=%0d scrub=%0d idle=%0d, want 0/0/0", stat_cpu, stat_scrub, stat_idle);
    end
    @(negedge cpu_clk);
    @(negedge cpu_clk);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32768; i++) ram[i] = 8'((i * 37) ^ (i >> 8));
    cpu_reset = 1'b1; slot = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    cpu_addr = 16'h0000; cpu_do = 8'h00; mark_we = 1'b0; mark_addr = 15'h0000;
    scrub_en = 1'b1;
`ifdef BUS_SCHED_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_scrub_page();
    test_cpu_preempt();
    test_remark();
    test_wrap();
    test_scrub_en();
    test_reset_mid_scrub();
`ifdef BUS_SCHED_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
